// File: rtl/reflet_ram_rmw.sv
// rtl/reflet_ram_rmw.sv - sub-word read / read-modify-write front end for a word-wide synchronous RAM
// Optional misalign_err output: define REFLET_RMW_MISALIGN_ERR_EN.
module reflet_ram_rmw #(
    parameter int word_size = 16,
    parameter int addr_size = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [addr_size-1:0] req_addr,
    input  logic [word_size-1:0] req_data,
    input  logic                 req_write_en,
    input  logic [3:0]           req_size,
    output logic                 rsp_valid,
    output logic [word_size-1:0] rsp_data,
    output logic [addr_size-1:0] ram_addr,
    output logic [word_size-1:0] ram_data_out,
    output logic                 ram_write_en,
    input  logic [word_size-1:0] ram_data_in
`ifdef REFLET_RMW_MISALIGN_ERR_EN
    ,
    output logic                 misalign_err
`endif
);

    localparam int lane_count = word_size / 8;
    localparam int off_w      = $clog2(lane_count);

    typedef enum logic [1:0] {
        IDLE,
        READ,
        WRITE,
        RESP
    } state_t;

    state_t state, state_next;

    // Access width in bits; sizes wider than the word collapse to a full-word access.
    function automatic int access_width(input logic [3:0] size);
        int w;
        if (size == 4'd0) begin
            w = word_size;
        end else begin
            w = 8 << (int'(size) - 1);
            if (w > word_size) w = word_size;
        end
        return w;
    endfunction

    function automatic logic [word_size-1:0] width_mask(input int width);
        logic [word_size-1:0] m;
        for (int i = 0; i < word_size; i++) m[i] = (i < width);
        return m;
    endfunction

    logic [off_w-1:0]     req_offset;
    logic [addr_size-1:0] req_word_addr;
    logic                 req_full;
    logic                 accept;

    logic [addr_size-1:0] lat_word_addr;
    logic [off_w-1:0]     lat_offset;
    logic [3:0]           lat_size;
    logic [word_size-1:0] lat_data;
    logic                 lat_write_en;

    int                   lat_shift;
    logic [word_size-1:0] lat_mask;
    logic [word_size-1:0] lane_mask;
    logic [word_size-1:0] merged;

    assign req_offset    = req_addr[off_w-1:0];
    assign req_word_addr = req_addr >> off_w;
    assign req_full      = (access_width(req_size) == word_size) && (req_offset == '0);
    assign accept        = req_valid && req_ready;

    // Shifting left truncates at the word boundary, which drops any lanes past the word end.
    assign lat_shift = int'(lat_offset) * 8;
    assign lat_mask  = width_mask(access_width(lat_size));
    assign lane_mask = lat_mask << lat_shift;
    assign merged    = (ram_data_in & ~lane_mask) | (((lat_data & lat_mask) << lat_shift) & lane_mask);

`ifdef REFLET_RMW_MISALIGN_ERR_EN
    logic req_misalign;
    assign req_misalign = (int'(req_offset) * 8 + access_width(req_size)) > word_size;
    assign misalign_err = !reset && accept && req_misalign;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lat_word_addr <= '0;
            lat_offset    <= '0;
            lat_size      <= '0;
            lat_data      <= '0;
            lat_write_en  <= 1'b0;
        end else if (accept) begin
            lat_word_addr <= req_word_addr;
            lat_offset    <= req_offset;
            lat_size      <= req_size;
            lat_data      <= req_data;
            lat_write_en  <= req_write_en;
        end
    end

    always_comb begin
        state_next   = state;
        req_ready    = 1'b0;
        rsp_valid    = 1'b0;
        rsp_data     = '0;
        ram_addr     = '0;
        ram_data_out = '0;
        ram_write_en = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    state_next = (req_write_en && req_full) ? WRITE : READ;
                end
            end
            READ: begin
                ram_addr   = lat_word_addr;
                state_next = lat_write_en ? WRITE : RESP;
            end
            WRITE: begin
                ram_addr     = lat_word_addr;
                ram_write_en = 1'b1;
                ram_data_out = merged;
                state_next   = IDLE;
            end
            RESP: begin
                rsp_valid  = 1'b1;
                rsp_data   = (ram_data_in >> lat_shift) & lat_mask;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_reflet_ram_rmw.sv
// tb/tb_reflet_ram_rmw.sv - directed self-checking bench for reflet_ram_rmw (64-bit words)
module tb_reflet_ram_rmw;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [63:0] req_addr = '0;
    logic [63:0] req_data = '0;
    logic        req_write_en = 1'b0;
    logic [3:0]  req_size = '0;
    logic        rsp_valid;
    logic [63:0] rsp_data;
    logic [63:0] ram_addr;
    logic [63:0] ram_data_out;
    logic        ram_write_en;
    logic [63:0] ram_data_in = '0;
`ifdef REFLET_RMW_MISALIGN_ERR_EN
    logic        misalign_err;
`endif

    logic [63:0] mem [0:15];
    logic        mem_init = 1'b1;
    int          wr_count = 0;
    int          rsp_count = 0;
    int          checks = 0;
    int          errors = 0;

    reflet_ram_rmw #(.word_size(64), .addr_size(64)) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_addr     (req_addr),
        .req_data     (req_data),
        .req_write_en (req_write_en),
        .req_size     (req_size),
        .rsp_valid    (rsp_valid),
        .rsp_data     (rsp_data),
        .ram_addr     (ram_addr),
        .ram_data_out (ram_data_out),
        .ram_write_en (ram_write_en),
        .ram_data_in  (ram_data_in)
`ifdef REFLET_RMW_MISALIGN_ERR_EN
        ,
        .misalign_err (misalign_err)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 16; i++) mem[i] <= '0;
            mem[0] <= 64'hFEDCBA9876543210;
        end else if (ram_write_en) begin
            mem[ram_addr[3:0]] <= ram_data_out;
        end
        ram_data_in <= mem[ram_addr[3:0]];
    end

    always @(posedge clk) begin
        if (ram_write_en) wr_count <= wr_count + 1;
        if (rsp_valid) rsp_count <= rsp_count + 1;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int tb_width(input logic [3:0] sz);
        int w;
        if (sz == 4'd0) return 64;
        w = 8 << (int'(sz) - 1);
        return (w > 64) ? 64 : w;
    endfunction

    // Called at a negedge in IDLE; returns at the negedge of the cycle after acceptance.
    task automatic issue(input logic we, input logic [3:0] sz, input logic [63:0] a, input logic [63:0] d);
        req_write_en = we;
        req_size     = sz;
        req_addr     = a;
        req_data     = d;
        req_valid    = 1'b1;
        #1;
        check("ready_at_accept", {63'd0, req_ready}, 64'd1);
`ifdef REFLET_RMW_MISALIGN_ERR_EN
        check("misalign_err", {63'd0, misalign_err},
              {63'd0, (int'(a[2:0]) * 8 + tb_width(sz)) > 64});
`endif
        @(negedge clk);
        req_valid = 1'b0;
        #1;
`ifdef REFLET_RMW_MISALIGN_ERR_EN
        check("misalign_after", {63'd0, misalign_err}, 64'd0);
`endif
    endtask

    task automatic read_check(input string tag, input logic [3:0] sz, input logic [63:0] a,
                              input logic [63:0] exp);
        issue(1'b0, sz, a, 64'd0);
        check({tag, "_n1_ready"}, {63'd0, req_ready}, 64'd0);
        check({tag, "_n1_rsp_valid"}, {63'd0, rsp_valid}, 64'd0);
        check({tag, "_n1_ram_addr"}, ram_addr, a >> 3);
        @(negedge clk);
        check({tag, "_n2_rsp_valid"}, {63'd0, rsp_valid}, 64'd1);
        check({tag, "_n2_rsp_data"}, rsp_data, exp);
        check({tag, "_n2_wen"}, {63'd0, ram_write_en}, 64'd0);
        @(negedge clk);
        check({tag, "_n3_rsp_valid"}, {63'd0, rsp_valid}, 64'd0);
        check({tag, "_n3_ready"}, {63'd0, req_ready}, 64'd1);
    endtask

    task automatic write_check(input string tag, input logic [3:0] sz, input logic [63:0] a,
                               input logic [63:0] d, input logic full, input logic [63:0] exp_out);
        issue(1'b1, sz, a, d);
        if (!full) begin
            check({tag, "_read_wen"}, {63'd0, ram_write_en}, 64'd0);
            check({tag, "_read_ram_addr"}, ram_addr, a >> 3);
            @(negedge clk);
        end
        check({tag, "_wen"}, {63'd0, ram_write_en}, 64'd1);
        check({tag, "_data_out"}, ram_data_out, exp_out);
        check({tag, "_ram_addr"}, ram_addr, a >> 3);
        check({tag, "_no_rsp"}, {63'd0, rsp_valid}, 64'd0);
        @(negedge clk);
        check({tag, "_wen_drop"}, {63'd0, ram_write_en}, 64'd0);
        check({tag, "_ready_back"}, {63'd0, req_ready}, 64'd1);
        check({tag, "_no_rsp_after"}, {63'd0, rsp_valid}, 64'd0);
    endtask

    initial begin
        #1 reset = 1'b1;
        #1;
        check("rst_ready", {63'd0, req_ready}, 64'd1);
        check("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        check("rst_rsp_data", rsp_data, 64'd0);
        check("rst_wen", {63'd0, ram_write_en}, 64'd0);
        check("rst_ram_addr", ram_addr, 64'd0);
        check("rst_data_out", ram_data_out, 64'd0);
        @(negedge clk);
        reset    = 1'b0;
        mem_init = 1'b0;

        read_check("rd_full_a0", 4'd0, 64'd0, 64'hFEDCBA9876543210);
        read_check("rd_byte_a3", 4'd1, 64'd3, 64'h76);
        write_check("wr_half_a4", 4'd2, 64'd4, 64'h88ff, 1'b0, 64'hFEDC88FF76543210);
        write_check("wr_full_a8", 4'd0, 64'd8, 64'h1122334455667788, 1'b1, 64'h1122334455667788);
        read_check("rd_clamp_a8", 4'd5, 64'd8, 64'h1122334455667788);
        read_check("rd_trunc_a6", 4'd3, 64'd6, 64'hFEDC);
        write_check("wr_trunc_a6", 4'd3, 64'd6, 64'hAABBCCDD, 1'b0, 64'hCCDD88FF76543210);
        read_check("rd_back_a0", 4'd0, 64'd0, 64'hCCDD88FF76543210);
        read_check("rd_back_a8", 4'd0, 64'd8, 64'h1122334455667788);

        issue(1'b1, 4'd1, 64'd1, 64'h55);
        check("abort_in_read_wen", {63'd0, ram_write_en}, 64'd0);
        reset = 1'b1;
        #1;
        check("abort_ready", {63'd0, req_ready}, 64'd1);
        check("abort_wen", {63'd0, ram_write_en}, 64'd0);
        check("abort_ram_addr", ram_addr, 64'd0);
        check("abort_data_out", ram_data_out, 64'd0);
        check("abort_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        check("abort_rsp_data", rsp_data, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("abort_ready_after", {63'd0, req_ready}, 64'd1);
        check("abort_no_write", wr_count, 64'd3);
        check("abort_no_rsp", rsp_count, 64'd6);

        read_check("rd_after_rst_a1", 4'd1, 64'd1, 64'h32);
        check("total_writes", wr_count, 64'd3);
        check("total_rsps", rsp_count, 64'd7);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/reflet_ram_rmw.md
REFLET_RAM_RMW -- requirements
Module: reflet_ram_rmw

Interface
REQ-001 SHALL have parameter word_size, default 16, data width in bits; multiple of 8, at least 16.
REQ-002 SHALL have parameter addr_size, default 16, byte address width in bits.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 req_valid  input  1  request present.
REQ-006 req_ready  output  1  block accepts a request this cycle.
REQ-007 req_addr  input  addr_size  byte address.
REQ-008 req_data  input  word_size  write data, right-aligned in the lowest lanes.
REQ-009 req_write_en  input  1  1 = write, 0 = read.
REQ-010 req_size  input  4  0 = full word; k>=1 = 8<<(k-1) bits, clamped to word_size.
REQ-011 rsp_valid  output  1  one-cycle pulse: read data valid.
REQ-012 rsp_data  output  word_size  read data, right-aligned, zero-extended.
REQ-013 ram_addr  output  addr_size  word address to RAM.
REQ-014 ram_data_out  output  word_size  RAM write data.
REQ-015 ram_write_en  output  1  RAM write strobe.
REQ-016 ram_data_in  input  word_size  RAM read data, valid one cycle after ram_addr is presented.

Function
- REQ-017: Byte offset SHALL be req_addr[log2(word_size/8)-1:0]; word address SHALL be req_addr shifted right by that width; byte lanes little-endian.
- REQ-018: States SHALL be IDLE, READ, WRITE, RESP; req_ready SHALL be 1 only in IDLE.
- REQ-019: Request SHALL be accepted when req_valid && req_ready; addr, data, size and write_en SHALL be latched on acceptance.
- REQ-020: Accepted read SHALL go IDLE->READ->RESP->IDLE; rsp_valid SHALL be high for exactly one cycle, two cycles after acceptance.
- REQ-021: In RESP, rsp_data SHALL be ram_data_in shifted right by offset*8, masked to the access width.
- REQ-022: An accepted full write (width = word_size, offset 0) SHALL go IDLE->WRITE->IDLE with no RAM read; ram_write_en SHALL be high one cycle after acceptance.
- REQ-023: An accepted partial write SHALL go IDLE->READ->WRITE->IDLE; in WRITE, ram_data_out SHALL equal ram_data_in with the addressed lanes replaced by the shifted req_data.
- REQ-024: ram_write_en SHALL be high only in WRITE, for exactly one cycle per write.
- REQ-025: ram_addr SHALL hold the latched word address in READ and WRITE; it SHALL be 0 in IDLE.
- REQ-026: Lanes beyond the word end (offset + width > word_size) SHALL be dropped; no second word SHALL be accessed.
- REQ-027: Requests presented outside IDLE SHALL be ignored; the upstream keeps them asserted until req_ready.
- REQ-028: rsp_valid SHALL never be asserted for a write.

Reset
- REQ-029: While reset is high, the block SHALL be in IDLE with req_ready=1, rsp_valid=0, rsp_data=0, ram_write_en=0, ram_addr=0, ram_data_out=0; these values SHALL apply immediately, independent of clk.
- REQ-030: Reset asserted in READ or WRITE SHALL abort the operation: no ram_write_en pulse and no rsp_valid afterwards.
- REQ-031: After reset deasserts, the first edge with req_valid=1 SHALL accept a request.

Configuration
- REQ-032: Macro REFLET_RMW_MISALIGN_ERR_EN, when defined, SHALL add output misalign_err (1 bit).
- REQ-033: With the macro, misalign_err SHALL pulse for one cycle, coincident with acceptance, when offset + width > word_size. Reset value is 0. The truncated access still proceeds per REQ-026.
- REQ-034: Without the macro, the port SHALL be absent and truncation SHALL be silent.

Verification (word_size=64, addr_size=64, RAM word 0 = FEDCBA9876543210)
- REQ-035: Read, req_size 0, addr 0, accepted at cycle N -> rsp_valid at N+2 and rsp_data=FEDCBA9876543210; ram_write_en never 1.
- REQ-036: Read, req_size 1, addr 3 -> rsp_data=0x76.
- REQ-037: Write, req_size 2, addr 4, data 0x88ff -> one ram_write_en pulse at N+2 with ram_data_out=FEDC88FF76543210 and ram_addr=0.
- REQ-038: Write, req_size 0, addr 8, data 0x1122334455667788 -> ram_write_en at N+1, ram_addr=1, no READ state visited.
- REQ-039: Partial write accepted, reset asserted during READ -> no ram_write_en pulse, all outputs at reset values; after release, req_ready=1.
- REQ-040: req_size 3, addr 6 -> with macro, misalign_err pulses once; without macro, no error output; a read returns 0xFEDC; a write changes only bytes 6 and 7.
